// File: rtl/iq_gen_hls_deadlock_report_pkg.sv
// Shared types and helpers for the iq_gen HLS deadlock reporter.
// Holds the FSM state encoding, AXIS info geometry and saturating arithmetic.
package iq_gen_hls_deadlock_report_pkg;

  localparam int unsigned CH_FIELD_W = 3;
  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned INFO_W     = CH_FIELD_W * NUM_CH;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WATCH    = 2'd1,
    ST_DEADLOCK = 2'd2
  } state_t;

  // Callers zero-extend to 32 bits and pass their own all-ones ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/iq_gen_hls_deadlock_report_sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear.
// Clear takes priority over increment; the value never wraps.
module iq_gen_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  import iq_gen_hls_deadlock_report_pkg::*;

  localparam logic [W-1:0] ALL_ONES = '1;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= W'(sat_inc(32'(count), 32'(ALL_ONES)));
    end
  end

endmodule

// File: rtl/iq_gen_hls_deadlock_report.sv
// Filters transient AXIS back-pressure from the HLS deadlock monitor and
// reports a sticky deadlock, one-shot interrupt, captured info and event count.
module iq_gen_hls_deadlock_report #(
  parameter int unsigned INFO_W = 9,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned EVT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block,
  input  logic [INFO_W-1:0] axis_block_info,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              clear,
  output logic              deadlock,
  output logic              deadlock_irq,
  output logic [INFO_W-1:0] deadlock_info,
  output logic [CNT_W-1:0]  block_cycles,
  output logic [EVT_W-1:0]  event_count
);
  import iq_gen_hls_deadlock_report_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] thr_eff;
  logic [CNT_W-1:0] thr_reg;
  logic             enter;
  logic             thr_load;
  logic             cnt_clr;

  assign thr_eff  = (threshold == '0) ? CNT_ONE : threshold;
  assign cnt_next = CNT_W'(sat_inc(32'(cnt), 32'(CNT_ONES)));

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    thr_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (block) begin
          thr_load = 1'b1;
          if (thr_eff == CNT_ONE) enter = 1'b1;
          else                    state_nxt = ST_WATCH;
        end
      end
      ST_WATCH: begin
        if (!block)                   state_nxt = ST_IDLE;
        else if (cnt_next >= thr_reg) enter = 1'b1;
      end
      ST_DEADLOCK: state_nxt = ST_DEADLOCK;
      default:     state_nxt = ST_IDLE;
    endcase
    if (enter) state_nxt = ST_DEADLOCK;
    // clear outranks any transition, including a detection on this very edge
    if (clear) begin
      state_nxt = ST_IDLE;
      enter     = 1'b0;
      thr_load  = 1'b0;
    end
  end

  // Outside DEADLOCK a low block restarts counting; inside it the count holds.
  assign cnt_clr = clear | ((state != ST_DEADLOCK) & ~block);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      thr_reg       <= '0;
      deadlock      <= 1'b0;
      deadlock_irq  <= 1'b0;
      deadlock_info <= '0;
    end else begin
      state        <= state_nxt;
      deadlock_irq <= enter;
      if (thr_load) thr_reg <= thr_eff;
      if (clear) begin
        deadlock      <= 1'b0;
        deadlock_info <= '0;
      end else if (enter) begin
        deadlock      <= 1'b1;
        deadlock_info <= axis_block_info;
      end
    end
  end

  iq_gen_sat_counter #(.W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (block),
    .count (cnt)
  );

  iq_gen_sat_counter #(.W(EVT_W)) u_evt (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .inc   (enter),
    .count (event_count)
  );

  assign block_cycles = cnt;

endmodule

// File: tb/tb_iq_gen_hls_deadlock_report.sv
// Scoreboard bench: a run-length reference model predicts each cycle's outputs
// for a 16-bit and a 4-bit counter instance; a monitor pops and compares.
module tb_iq_gen_hls_deadlock_report;

  logic        clock = 1'b0;
  logic        reset, block, clear;
  logic [8:0]  info;
  logic [15:0] thr;
  logic [3:0]  thr4;

  logic        dl0, irq0, dl1, irq1;
  logic [8:0]  dinfo0, dinfo1;
  logic [15:0] bc0;
  logic [3:0]  bc1;
  logic [7:0]  ev0, ev1;

  assign thr4 = thr[3:0];

  always #5 clock = ~clock;

  iq_gen_hls_deadlock_report #(.INFO_W(9), .CNT_W(16), .EVT_W(8)) dut (
    .clock(clock), .reset(reset), .block(block), .axis_block_info(info),
    .threshold(thr), .clear(clear), .deadlock(dl0), .deadlock_irq(irq0),
    .deadlock_info(dinfo0), .block_cycles(bc0), .event_count(ev0)
  );

  iq_gen_hls_deadlock_report #(.INFO_W(9), .CNT_W(4), .EVT_W(8)) dut4 (
    .clock(clock), .reset(reset), .block(block), .axis_block_info(info),
    .threshold(thr4), .clear(clear), .deadlock(dl1), .deadlock_irq(irq1),
    .deadlock_info(dinfo1), .block_cycles(bc1), .event_count(ev1)
  );

  typedef struct {
    logic        dl;
    logic        irq;
    logic [8:0]  info;
    int unsigned bc;
    int unsigned ev;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  // Reference model: "run" is the length of the current consecutive-block run.
  int unsigned m_run[2];
  int unsigned m_thr[2];
  int unsigned m_ev[2];
  logic        m_dl[2];
  logic        m_irq[2];
  logic [8:0]  m_info[2];

  task automatic model_step(input int k, input logic b, input logic [8:0] inf,
                            input int unsigned thr_in, input logic clr, input logic rst);
    int unsigned cmax;
    exp_t e;
    cmax = (k == 0) ? 65535 : 15;
    m_irq[k] = 1'b0;
    if (rst) begin
      m_run[k] = 0; m_thr[k] = 0; m_ev[k] = 0; m_dl[k] = 1'b0; m_info[k] = '0;
    end else if (clr) begin
      m_run[k] = 0; m_dl[k] = 1'b0; m_info[k] = '0;
    end else if (!m_dl[k]) begin
      if (b) begin
        if (m_run[k] == 0) m_thr[k] = (thr_in == 0) ? 1 : thr_in;
        m_run[k] = (m_run[k] < cmax) ? m_run[k] + 1 : cmax;
        if (m_run[k] >= m_thr[k]) begin
          m_dl[k] = 1'b1; m_irq[k] = 1'b1; m_info[k] = inf;
          m_ev[k] = (m_ev[k] < 255) ? m_ev[k] + 1 : 255;
        end
      end else begin
        m_run[k] = 0;
      end
    end else if (b) begin
      m_run[k] = (m_run[k] < cmax) ? m_run[k] + 1 : cmax;
    end
    e.dl = m_dl[k]; e.irq = m_irq[k]; e.info = m_info[k];
    e.bc = m_run[k]; e.ev = m_ev[k];
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic step(input logic b, input logic [8:0] inf, input logic [15:0] t,
                      input logic clr, input logic rst);
    @(negedge clock);
    block = b; info = inf; thr = t; clear = clr; reset = rst;
    model_step(0, b, inf, int'(t), clr, rst);
    model_step(1, b, inf, int'(t[3:0]), clr, rst);
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("deadlock",      int'(dl0),    int'(e.dl));
        chk("deadlock_irq",  int'(irq0),   int'(e.irq));
        chk("deadlock_info", int'(dinfo0), int'(e.info));
        chk("block_cycles",  int'(bc0),    e.bc);
        chk("event_count",   int'(ev0),    e.ev);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("w4_deadlock",     int'(dl1),    int'(e.dl));
        chk("w4_irq",          int'(irq1),   int'(e.irq));
        chk("w4_info",         int'(dinfo1), int'(e.info));
        chk("w4_block_cycles", int'(bc1),    e.bc);
        chk("w4_event_count",  int'(ev1),    e.ev);
      end
    end
  end

  initial begin
    block = 0; info = '0; thr = 16'd4; clear = 0; reset = 1;
    step(0, 9'h000, 4, 0, 1);
    step(0, 9'h000, 4, 0, 1);
    // short run that never reaches threshold 4
    repeat (3) step(1, 9'h0AA, 4, 0, 0);
    repeat (2) step(0, 9'h000, 4, 0, 0);
    // run of 4 with capture info on the fourth cycle
    repeat (3) step(1, 9'h011, 4, 0, 0);
    step(1, 9'h1F9, 4, 0, 0);
    repeat (3) step(0, 9'h055, 4, 0, 0);
    // clear in DEADLOCK, then a fresh deadlock
    step(0, 9'h123, 4, 1, 0);
    repeat (6) step(1, 9'h0F0, 4, 0, 0);
    step(0, 9'h000, 4, 1, 0);
    // threshold 0 acts as 1
    step(1, 9'h1C3, 0, 0, 0);
    repeat (2) step(0, 9'h000, 0, 0, 0);
    step(0, 9'h000, 4, 1, 0);
    // clear on the detection edge, then counting restarts
    repeat (3) step(1, 9'h007, 4, 0, 0);
    step(1, 9'h1FF, 4, 1, 0);
    repeat (5) step(1, 9'h038, 4, 0, 0);
    // reset while in DEADLOCK
    step(1, 9'h000, 4, 0, 1);
    step(0, 9'h000, 4, 0, 0);
    // long run against threshold 15; the 4-bit counter must saturate
    repeat (20) step(1, 9'h101, 15, 0, 0);
    step(0, 9'h000, 15, 1, 0);
    step(0, 9'h000, 15, 0, 0);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [15:0] t;
      t = ($urandom_range(0, 9) == 0) ? 16'd15 : 16'($urandom_range(0, 6));
      step($urandom_range(0, 9) < 7, 9'($urandom), t,
           $urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0);
    end
    @(posedge clock);
    #3;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
